band_mixer: RTL and testbench

- Downstream consumer of the per-band playback stages (band0..bandN playback).
- Captures one signed 16-bit sample per band per 44 kHz frame and applies a per-band programmable gain to each.
- Sums all bands with a single shared serial multiply-accumulate, saturates the sum and emits one mixed 16-bit sample per frame to the audio output path.
- Runs in the 4.4 MHz playback clock domain; 100 clocks per frame leaves ample time for the serial MAC.

---
 rtl/band_mixer.sv | 145 ++++++++++++++
 tb/tb_band_mixer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/band_mixer.sv
// band_mixer: captures one sample per band per frame, applies per-band gain and mixes
// them with one shared serial MAC. Optional clip flag: BAND_MIXER_CLIP_FLAG_EN.
module band_mixer #(
    parameter int  NUM_BANDS = 8,
    parameter int  GAIN_W    = 16,
    localparam int ACC_W     = 33 + $clog2(NUM_BANDS),
    localparam int AW        = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [16*NUM_BANDS-1:0] band_data,
    input  logic [NUM_BANDS-1:0]    band_valid,
    input  logic                    gain_we,
    input  logic [AW-1:0]           gain_addr,
    input  logic [GAIN_W-1:0]       gain_data,
    output logic [15:0]             mix_out,
    output logic                    mix_valid,
`ifdef BAND_MIXER_CLIP_FLAG_EN
    output logic                    clip_sticky,
    input  logic                    clip_clear,
`endif
    output logic                    overrun
);

    localparam int                      PROD_W  = 17 + GAIN_W;
    localparam logic [GAIN_W-1:0]       UNITY   = GAIN_W'(16384);
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32768);

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    state_t                   state;
    state_t                   state_nxt;
    logic signed [15:0]       cap  [NUM_BANDS];
    logic signed [15:0]       work [NUM_BANDS];
    logic [GAIN_W-1:0]        gain [NUM_BANDS];
    logic [NUM_BANDS-1:0]     pending;
    logic [AW-1:0]            k;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  scaled;
    logic signed [PROD_W-1:0] prod;
    logic [15:0]              sat;
    logic                     start;
    logic                     last;

    assign start  = (state == IDLE) && (&pending);
    assign last   = (k == AW'(NUM_BANDS - 1));
    assign prod   = work[k] * $signed({1'b0, gain[k]});
    assign scaled = acc >>> 14;

    always_comb begin
        sat = scaled[15:0];
        if (scaled > SAT_MAX) begin
            sat = 16'h7fff;
        end else if (scaled < SAT_MIN) begin
            sat = 16'h8000;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = MAC;
            MAC:     if (last) state_nxt = OUT;
            OUT:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending   <= '0;
            overrun   <= 1'b0;
            k         <= '0;
            acc       <= '0;
            mix_out   <= '0;
            mix_valid <= 1'b0;
            for (int unsigned b = 0; b < NUM_BANDS; b++) begin
                cap[b]  <= '0;
                work[b] <= '0;
                gain[b] <= UNITY;
            end
        end else begin
            mix_valid <= 1'b0;
            // A strobe on the frame-start edge belongs to the next frame, so it is not an overrun.
            overrun   <= |(band_valid & pending & ~{NUM_BANDS{start}});
            for (int unsigned b = 0; b < NUM_BANDS; b++) begin
                if (band_valid[b]) begin
                    cap[b]     <= band_data[16*b +: 16];
                    pending[b] <= 1'b1;
                end else if (start) begin
                    pending[b] <= 1'b0;
                end
            end
            if (gain_we && (32'(gain_addr) < NUM_BANDS)) begin
                gain[gain_addr] <= gain_data;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        for (int unsigned b = 0; b < NUM_BANDS; b++) begin
                            work[b] <= cap[b];
                        end
                        acc <= '0;
                        k   <= '0;
                    end
                end
                MAC: begin
                    acc <= acc + ACC_W'(prod);
                    k   <= k + 1'b1;
                end
                OUT: begin
                    mix_out   <= sat;
                    mix_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef BAND_MIXER_CLIP_FLAG_EN
    logic clipped;

    assign clipped = (scaled > SAT_MAX) || (scaled < SAT_MIN);

    always_ff @(posedge clk) begin
        if (rst) begin
            clip_sticky <= 1'b0;
        end else if ((state == OUT) && clipped) begin
            clip_sticky <= 1'b1;
        end else if (clip_clear) begin
            clip_sticky <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_band_mixer.sv
// tb_band_mixer: directed and randomized frames checked against a frame-level reference model.
`timescale 1ns/1ps
module tb_band_mixer;

    localparam int NB = 8;
    localparam int AW = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic [16*NB-1:0] band_data;
    logic [NB-1:0]   band_valid;
    logic            gain_we;
    logic [AW-1:0]   gain_addr;
    logic [15:0]     gain_data;
    logic [15:0]     mix_out;
    logic            mix_valid;
    logic            overrun;
`ifdef BAND_MIXER_CLIP_FLAG_EN
    logic            clip_sticky;
    logic            clip_clear;
`endif

    band_mixer #(.NUM_BANDS(NB), .GAIN_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .band_data  (band_data),
        .band_valid (band_valid),
        .gain_we    (gain_we),
        .gain_addr  (gain_addr),
        .gain_data  (gain_data),
        .mix_out    (mix_out),
        .mix_valid  (mix_valid),
`ifdef BAND_MIXER_CLIP_FLAG_EN
        .clip_sticky(clip_sticky),
        .clip_clear (clip_clear),
`endif
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    int     cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int     n_checks = 0;
    int     n_errors = 0;
    int     mv_cnt = 0;
    int     last_mv_cyc = 0;
    int     ovr_cnt = 0;
    int     exp_ovr = 0;
    int     last_edge = 0;
    longint gain_m [NB];
    longint cap_m  [NB];
    bit     pend_m [NB];
    longint frame_v[NB];
    longint exp_q  [$];

    task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Frame-level reference: a frame completes once every band has a fresh sample.
    function automatic void model_reset();
        foreach (gain_m[b]) begin
            gain_m[b] = 16384;
            cap_m[b]  = 0;
            pend_m[b] = 0;
        end
        exp_q.delete();
    endfunction

    function automatic void model_strobe(int b, longint v);
        bit     all;
        longint sum;
        longint s;
        if (pend_m[b]) exp_ovr++;
        cap_m[b]  = v;
        pend_m[b] = 1;
        all = 1;
        foreach (pend_m[i]) if (!pend_m[i]) all = 0;
        if (all) begin
            sum = 0;
            foreach (cap_m[i]) sum += cap_m[i] * gain_m[i];
            s = sum >>> 14;
            if (s > 32767) s = 32767;
            if (s < -32768) s = -32768;
            exp_q.push_back(s);
            foreach (pend_m[i]) pend_m[i] = 0;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (mix_valid === 1'b1) begin
            mv_cnt++;
            last_mv_cyc = cyc;
        end
        if (overrun === 1'b1) ovr_cnt++;
    endtask

    task automatic strobe(input logic [NB-1:0] mask);
        for (int b = 0; b < NB; b++) begin
            if (mask[b]) begin
                band_data[16*b +: 16] = 16'(frame_v[b]);
                model_strobe(b, frame_v[b]);
            end
        end
        band_valid = mask;
        tick();
        band_valid = '0;
        last_edge  = cyc;
    endtask

    task automatic write_gain(input int a, input int g);
        gain_we   = 1'b1;
        gain_addr = AW'(a);
        gain_data = 16'(g);
        tick();
        gain_we   = 1'b0;
        gain_m[a] = g;
    endtask

    // mode 0: all bands in one cycle; 1: band k on cycle k; 2: random slots
    task automatic send_frame(input int mode);
        int slot[NB];
        int maxs;
        logic [NB-1:0] mask;
        maxs = 0;
        for (int b = 0; b < NB; b++) begin
            slot[b] = (mode == 0) ? 0 : (mode == 1) ? b : int'($urandom_range(0, 4));
            if (slot[b] > maxs) maxs = slot[b];
        end
        for (int c = 0; c <= maxs; c++) begin
            mask = '0;
            for (int b = 0; b < NB; b++) if (slot[b] == c) mask[b] = 1'b1;
            if (mask != '0) strobe(mask);
            else tick();
        end
    endtask

    task automatic wait_mix(input string tag, input int t_last);
        int     mv0;
        int     budget;
        longint e;
        mv0    = mv_cnt;
        budget = 60;
        while (mv_cnt == mv0 && budget > 0) begin
            tick();
            budget--;
        end
        check({tag, "_strobe"}, mv_cnt - mv0, 1);
        check({tag, "_latency"}, last_mv_cyc - t_last, NB + 2);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : -99999;
        check({tag, "_value"}, $signed(mix_out), e);
        check({tag, "_overrun"}, ovr_cnt, exp_ovr);
        repeat (3) tick();
        check({tag, "_single"}, mv_cnt - mv0, 1);
        check({tag, "_hold"}, $signed(mix_out), e);
    endtask

    initial begin
        int mv0;
        int t0;
        longint e;
        rst        = 1'b1;
        band_valid = '0;
        band_data  = '0;
        gain_we    = 1'b0;
        gain_addr  = '0;
        gain_data  = '0;
`ifdef BAND_MIXER_CLIP_FLAG_EN
        clip_clear = 1'b0;
`endif
        model_reset();
        tick();
        tick();
        check("rst_mix_out", mix_out, 0);
        check("rst_mix_valid", mix_valid, 0);
        check("rst_overrun", overrun, 0);
`ifdef BAND_MIXER_CLIP_FLAG_EN
        check("rst_clip", clip_sticky, 0);
`endif
        rst = 1'b0;
        tick();

        foreach (frame_v[b]) frame_v[b] = 1000;
        send_frame(0);
        wait_mix("unity", last_edge);

        write_gain(2, 8192);
        foreach (frame_v[b]) frame_v[b] = 0;
        frame_v[2] = 2000;
        send_frame(1);
        wait_mix("stagger", last_edge);

        foreach (frame_v[b]) frame_v[b] = 30000;
        send_frame(0);
        wait_mix("sat_pos", last_edge);
`ifdef BAND_MIXER_CLIP_FLAG_EN
        check("clip_set", clip_sticky, 1);
        clip_clear = 1'b1;
        tick();
        clip_clear = 1'b0;
        check("clip_cleared", clip_sticky, 0);
`endif

        // Negative saturation, stepped by hand so a clear can coincide with the output edge.
        foreach (frame_v[b]) frame_v[b] = -30000;
        mv0 = mv_cnt;
        strobe('1);
        repeat (NB + 1) tick();
        check("sat_neg_early", mv_cnt - mv0, 0);
`ifdef BAND_MIXER_CLIP_FLAG_EN
        clip_clear = 1'b1;
`endif
        tick();
`ifdef BAND_MIXER_CLIP_FLAG_EN
        clip_clear = 1'b0;
        check("clip_set_wins", clip_sticky, 1);
`endif
        check("sat_neg_valid", mix_valid, 1);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : -99999;
        check("sat_neg_value", $signed(mix_out), e);
        repeat (3) tick();

        foreach (frame_v[b]) frame_v[b] = 0;
        frame_v[2] = -3;
        send_frame(0);
        wait_mix("floor_neg", last_edge);
        frame_v[2] = 3;
        send_frame(0);
        wait_mix("floor_pos", last_edge);

        foreach (frame_v[b]) frame_v[b] = 0;
        frame_v[1] = 100;
        frame_v[0] = 5;
        strobe(8'h01);
        frame_v[0] = 7;
        strobe(8'h01);
        strobe(8'hFE);
        wait_mix("overrun", last_edge);

        // Next-frame strobe on the same edge that clears pending.
        foreach (frame_v[b]) frame_v[b] = 10;
        strobe('1);
        t0 = last_edge;
        foreach (frame_v[b]) frame_v[b] = 20;
        strobe(8'h01);
        wait_mix("clr_edge_a", t0);
        strobe(8'hFE);
        wait_mix("clr_edge_b", last_edge);

        write_gain(1, 4096);
        foreach (frame_v[b]) frame_v[b] = 50;
        strobe('1);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        mv0 = mv_cnt;
        check("midrst_mix_out", mix_out, 0);
        check("midrst_mix_valid", mix_valid, 0);
        repeat (20) tick();
        check("midrst_no_strobe", mv_cnt - mv0, 0);
        foreach (frame_v[b]) frame_v[b] = 100;
        send_frame(2);
        wait_mix("midrst_next", last_edge);

        for (int f = 0; f < 25; f++) begin
            repeat ($urandom_range(0, 3)) begin
                case ($urandom_range(0, 2))
                    0:       write_gain($urandom_range(0, NB - 1), $urandom_range(0, 65535));
                    1:       write_gain($urandom_range(0, NB - 1), 16384);
                    default: write_gain($urandom_range(0, NB - 1), $urandom_range(0, 20000));
                endcase
            end
            foreach (frame_v[b]) begin
                case ($urandom_range(0, 2))
                    0:       frame_v[b] = longint'($signed(16'($urandom())));
                    1:       frame_v[b] = longint'($urandom_range(0, 4000)) - 2000;
                    default: frame_v[b] = 0;
                endcase
            end
            send_frame(2);
            wait_mix("rand", last_edge);
            repeat ($urandom_range(0, 5)) tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
